// File: rtl/rca_result_accumulator.sv
// Sums COUNT accepted ripple-carry adder results ({carry, sum}) into a widened block total,
// counting carry-outs, and presents each completed block on a valid/ready handshake.
module rca_result_accumulator #(
  parameter int WIDTH = 30,
  parameter int COUNT = 16,
  localparam int ACC_W = WIDTH + 1 + $clog2(COUNT),
  localparam int CNT_W = $clog2(COUNT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH:0]   i_result,
  input  logic             i_clear,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACC_W-1:0] o_sum,
  output logic [CNT_W-1:0] o_carry_cnt,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ccnt_q;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] carry_cnt_q;
  logic             valid_q;

  logic             xfer_s;
  logic             last_s;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] ccnt_d;

  assign o_ready     = !i_rst && (state_q != HOLD) && !i_clear;
  assign o_valid     = valid_q;
  assign o_sum       = sum_q;
  assign o_carry_cnt = carry_cnt_q;
  assign o_busy      = (state_q == ACCUM);

  // Running totals after a transfer; the first sample of a block starts from zero.
  always_comb begin
    xfer_s = i_valid && o_ready;
    if (state_q == ACCUM) begin
      acc_d  = acc_q + ACC_W'(i_result);
      cnt_d  = cnt_q + CNT_W'(1'b1);
      ccnt_d = ccnt_q + CNT_W'(i_result[WIDTH]);
    end else begin
      acc_d  = ACC_W'(i_result);
      cnt_d  = CNT_W'(1'b1);
      ccnt_d = CNT_W'(i_result[WIDTH]);
    end
    last_s = (cnt_d == COUNT_C);
  end

  // Block FSM with registered outputs; clear aborts the block and zeroes the presented result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      ccnt_q      <= {CNT_W{1'b0}};
      sum_q       <= {ACC_W{1'b0}};
      carry_cnt_q <= {CNT_W{1'b0}};
      valid_q     <= 1'b0;
    end else if (i_clear) begin
      state_q     <= IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      ccnt_q      <= {CNT_W{1'b0}};
      sum_q       <= {ACC_W{1'b0}};
      carry_cnt_q <= {CNT_W{1'b0}};
      valid_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (xfer_s) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ccnt_q <= ccnt_d;
            if (last_s) begin
              state_q     <= HOLD;
              sum_q       <= acc_d;
              carry_cnt_q <= ccnt_d;
              valid_q     <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end else begin
            state_q <= state_q;
          end
        end
        HOLD: begin
          if (i_ready) begin
            state_q <= IDLE;
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            ccnt_q  <= {CNT_W{1'b0}};
            valid_q <= 1'b0;
          end else begin
            state_q <= HOLD;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_result_accumulator.sv
// Directed self-checking bench for rca_result_accumulator with WIDTH=30, COUNT=4.
module tb_rca_result_accumulator;

  localparam int WIDTH = 30;
  localparam int COUNT = 4;
  localparam int ACC_W = WIDTH + 1 + $clog2(COUNT);
  localparam int CNT_W = $clog2(COUNT + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             out_ready_s;
  logic [WIDTH:0]   in_result;
  logic             clear;
  logic             out_valid_s;
  logic             ds_ready;
  logic [ACC_W-1:0] sum_s;
  logic [CNT_W-1:0] carry_cnt_s;
  logic             busy_s;

  int vectors    = 0;
  int miscompares = 0;

  rca_result_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (in_valid),
    .o_ready     (out_ready_s),
    .i_result    (in_result),
    .i_clear     (clear),
    .o_valid     (out_valid_s),
    .i_ready     (ds_ready),
    .o_sum       (sum_s),
    .o_carry_cnt (carry_cnt_s),
    .o_busy      (busy_s)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer followed by a number of idle cycles with junk on the data bus.
  task automatic send(input logic [WIDTH:0] v, input int gaps);
    in_valid  = 1'b1;
    in_result = v;
    step();
    in_valid  = 1'b0;
    in_result = 31'h2AAA_5555;
    for (int g = 0; g < gaps; g++) step();
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] s, input logic [63:0] c);
    chk({tag, "_valid"}, 64'(out_valid_s), 64'(v));
    chk({tag, "_sum"}, 64'(sum_s), s);
    chk({tag, "_ccnt"}, 64'(carry_cnt_s), c);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; clear = 1'b0; ds_ready = 1'b0;
    step();
    step();
    chk_out("reset", 1'b0, 64'd0, 64'd0);
    chk("reset_busy", 64'(busy_s), 64'd0);
    chk("reset_ready", 64'(out_ready_s), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 64'(out_ready_s), 64'd1);

    // 1: reset mid-block
    send(31'd11, 0);
    send(31'd22, 0);
    chk("t1_busy", 64'(busy_s), 64'd1);
    rst = 1'b1;
    #1;
    chk_out("t1_rst", 1'b0, 64'd0, 64'd0);
    chk("t1_rst_busy", 64'(busy_s), 64'd0);
    step();
    rst = 1'b0;
    send(31'd1, 0);
    send(31'd1, 0);
    send(31'd1, 0);
    chk("t1_three", 64'(out_valid_s), 64'd0);
    send(31'd1, 0);
    chk_out("t1_fresh", 1'b1, 64'd4, 64'd0);
    ds_ready = 1'b1;
    step();
    chk("t1_drain", 64'(out_valid_s), 64'd0);

    // 2: back-to-back 1,2,3,4 with downstream ready
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_result = 31'(i);
      chk("t2_ready", 64'(out_ready_s), 64'd1);
      step();
      if (i < 4) chk("t2_pending", 64'(out_valid_s), 64'd0);
    end
    in_valid = 1'b0;
    chk_out("t2_blk", 1'b1, 64'd10, 64'd0);
    chk("t2_hold_ready", 64'(out_ready_s), 64'd0);
    step();
    chk_out("t2_after", 1'b0, 64'd10, 64'd0);
    chk("t2_idle_ready", 64'(out_ready_s), 64'd1);

    // 3: maximum values with carry set
    ds_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(31'h7FFF_FFFF, 0);
    chk_out("t3_max", 1'b1, 64'h1_FFFF_FFFC, 64'd4);

    // 4: backpressure in HOLD with changing input
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_result = 31'(i * 1234 + 7);
      chk("t4_ready", 64'(out_ready_s), 64'd0);
      step();
      chk_out("t4_stall", 1'b1, 64'h1_FFFF_FFFC, 64'd4);
    end
    in_valid = 1'b0;
    ds_ready = 1'b1;
    step();
    chk("t4_drain", 64'(out_valid_s), 64'd0);
    ds_ready = 1'b0;

    // 5: bubbles between transfers
    send(31'd5, 1);
    chk("t5_a", 64'(out_valid_s), 64'd0);
    send(31'd6, 2);
    chk("t5_b", 64'(out_valid_s), 64'd0);
    send(31'd7, 3);
    chk("t5_c", 64'(out_valid_s), 64'd0);
    chk("t5_busy", 64'(busy_s), 64'd1);
    send(31'd8, 0);
    chk_out("t5_blk", 1'b1, 64'd26, 64'd0);
    ds_ready = 1'b1;
    step();
    ds_ready = 1'b0;
    chk_out("t5_after", 1'b0, 64'd26, 64'd0);

    // 6: clear aborts a partial block
    send(31'd100, 0);
    send(31'h4000_0064, 0);
    chk("t6_busy", 64'(busy_s), 64'd1);
    clear = 1'b1;
    in_valid = 1'b1;
    in_result = 31'd999;
    #1;
    chk("t6_clr_ready", 64'(out_ready_s), 64'd0);
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    chk_out("t6_clr", 1'b0, 64'd0, 64'd0);
    chk("t6_clr_busy", 64'(busy_s), 64'd0);
    for (int i = 0; i < 3; i++) send(31'd1, 0);
    chk("t6_pending", 64'(out_valid_s), 64'd0);
    send(31'd1, 0);
    chk_out("t6_blk", 1'b1, 64'd4, 64'd0);

    // mixed carry bits
    ds_ready = 1'b1;
    step();
    ds_ready = 1'b0;
    send(31'h4000_0000, 0);
    send(31'd3, 0);
    send(31'h4000_0001, 0);
    send(31'd2, 0);
    chk_out("mix_blk", 1'b1, 64'h8000_0006, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
